serial_frame_tx: RTL and testbench

Upstream stage of the 32-stage serial delay line: accepts parallel bytes over a valid/ready handshake and emits a framed, MSB-first serial bit stream, one bit per clock, on the line's serial input pin. Each frame is a fixed preamble followed by the data word, with an optional parity bit. The preamble lets the delay-line taps show a recognisable marker on the outputs.

---
 rtl/serial_frame_tx_pkg.sv | 11 +
 rtl/serial_frame_tx_if.sv | 18 +
 rtl/serial_frame_tx.sv | 105 ++++++++++
 tb/tb_serial_frame_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg: shared state type, default geometry and counter sizing for serial_frame_tx
package serial_frame_tx_pkg;
    typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} state_t;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_PRE_W = 4;
    localparam logic [DEF_PRE_W-1:0] DEF_PRE_PATTERN = 4'b1011;
    function automatic int cnt_width(input int pre_w, input int data_w);
        return $clog2((pre_w > data_w ? pre_w : data_w) + 1);
    endfunction
    localparam int DEF_CNT_W = cnt_width(DEF_PRE_W, DEF_DATA_W);
endpackage

// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: word handshake in, framed serial stream out
//   in_data/in_valid/in_ready : producer word handshake
//   ser_out/frame_start/busy  : serial line and frame markers
//   slave = transmitter side, master = producer/observer side
interface serial_frame_tx_if
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_out;
    logic              frame_start;
    logic              busy;
    modport slave (input in_data, in_valid, output in_ready, ser_out, frame_start, busy);
    modport master (output in_data, in_valid, input in_ready, ser_out, frame_start, busy);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: frames parallel words as preamble + MSB-first data (+ optional even parity) on a serial line
//   clk, rst        : clock, asynchronous active-high reset
//   bus.in_data     : word latched on in_valid && in_ready
//   bus.in_valid    : word offered
//   bus.in_ready    : high in IDLE and in the final bit cycle of a frame
//   bus.ser_out     : registered serial bit
//   bus.frame_start : registered pulse while the first preamble bit is on ser_out
//   bus.busy        : registered, high while any frame bit is on ser_out
//   SERIAL_FRAME_TX_PARITY_EN : append one even-parity bit after the data LSB
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PRE_W = DEF_PRE_W,
    parameter logic [PRE_W-1:0] PRE_PATTERN = DEF_PRE_PATTERN,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic clk,
    input logic rst,
    serial_frame_tx_if.slave bus
);
    localparam int CW = cnt_width(PRE_W, DATA_W);
    localparam int SR_W = PRE_W + DATA_W;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SR_W-1:0] sr;
    logic            last_pre;
    logic            last_data;
    logic            accept;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic            par;
`endif
    always_comb begin
        last_pre = cnt == CW'(PRE_W - 1);
        last_data = cnt == CW'(DATA_W - 1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        bus.in_ready = state == IDLE || state == PAR;
`else
        bus.in_ready = state == IDLE || (state == DATA && last_data);
`endif
        accept = bus.in_valid && bus.in_ready;
    end
    // Preamble and word share one shift register; its MSB is always the next bit to send,
    // so the preamble-to-data boundary needs no special case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            bus.ser_out <= IDLE_LEVEL;
            bus.frame_start <= 1'b0;
            bus.busy <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par <= 1'b0;
`endif
        end else begin
            bus.frame_start <= accept;
            if (accept) begin
                state <= PRE;
                cnt <= '0;
                sr <= {PRE_PATTERN, bus.in_data} << 1;
                bus.ser_out <= PRE_PATTERN[PRE_W-1];
                bus.busy <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                par <= ^bus.in_data;
`endif
            end else begin
                case (state)
                    PRE: begin
                        state <= last_pre ? DATA : PRE;
                        cnt <= last_pre ? '0 : cnt + 1'b1;
                        bus.ser_out <= sr[SR_W-1];
                        sr <= sr << 1;
                    end
                    DATA: begin
                        if (!last_data) begin
                            cnt <= cnt + 1'b1;
                            bus.ser_out <= sr[SR_W-1];
                            sr <= sr << 1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        end else begin
                            state <= PAR;
                            cnt <= '0;
                            bus.ser_out <= par;
                        end
`else
                        end else begin
                            state <= IDLE;
                            cnt <= '0;
                            bus.ser_out <= IDLE_LEVEL;
                            bus.busy <= 1'b0;
                        end
`endif
                    end
                    default: begin
                        state <= IDLE;
                        cnt <= '0;
                        bus.ser_out <= IDLE_LEVEL;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: frame-level model plus literal stream checks for serial_frame_tx
module tb_serial_frame_tx;
    localparam int DW = 8;
    localparam int PW = 4;
    localparam logic [3:0] PAT = 4'b1011;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int L = PW + DW + 1;
`else
    localparam int L = PW + DW;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    bit [1:0] mq[$];
    bit m_ser, m_busy, m_fs;
    bit [2:0] cap[$];
    int at, at2;

    serial_frame_tx_if #(.DATA_W(DW)) bus ();
    serial_frame_tx #(.DATA_W(DW), .PRE_W(PW), .PRE_PATTERN(PAT), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] frame_val(input logic [7:0] d);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        return {19'b0, PAT, d, ^d};
`else
        return {20'b0, PAT, d};
`endif
    endfunction

    function automatic void push_frame(input logic [7:0] d);
        logic [31:0] fv = frame_val(d);
        for (int j = L - 1; j >= 0; j--) mq.push_back({j == L - 1, fv[j]});
    endfunction

    // Line model: queue of bits still to appear; producer may hand over a word only when
    // nothing remains queued behind the bit currently on the line.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ser <= 1'b0;
            m_busy <= 1'b0;
            m_fs <= 1'b0;
        end else begin
            if (bus.in_valid && mq.size() == 0) push_frame(bus.in_data);
            if (mq.size() != 0) begin
                {m_fs, m_ser} <= mq.pop_front();
                m_busy <= 1'b1;
            end else begin
                m_fs <= 1'b0;
                m_ser <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cap.push_back({bus.busy, bus.frame_start, bus.ser_out});
        n_vec++;
        if ({bus.in_ready, bus.ser_out, bus.busy, bus.frame_start} !== {mq.size() == 0, m_ser, m_busy, m_fs}) begin
            n_err++;
            $display("FAIL cycle @%0t rdy/ser/busy/fs: got %b%b%b%b expected %b%b%b%b", $time,
                     bus.in_ready, bus.ser_out, bus.busy, bus.frame_start, mq.size() == 0, m_ser, m_busy, m_fs);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic offer(input logic [7:0] d, input bit drop);
        bit ok = 1'b0;
        bus.in_data = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("offer_timeout", 32'(ok), 32'd1);
        if (drop) bus.in_valid = 1'b0;
    endtask

    function automatic int count_bit(input int b, input int from, input int upto);
        int n = 0;
        for (int i = from; i < upto && i < cap.size(); i++) n += int'(cap[i][b]);
        return n;
    endfunction

    function automatic int find_start(input int from);
        for (int i = from; i < cap.size(); i++) if (cap[i][1]) return i;
        return -1;
    endfunction

    task automatic stream(input string name, input logic [31:0] exp, input int nb, output int s);
        logic [31:0] v = '0;
        s = find_start(0);
        if (s < 0 || s + nb > cap.size()) v = '1;
        else for (int j = 0; j < nb; j++) v = {v[30:0], cap[s+j][0]};
        chk(name, v, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'hC3;
        tick(5);
        chk("reset_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_no_busy", 32'(count_bit(2, 0, cap.size())), 32'd0);
        chk("reset_no_start", 32'(count_bit(1, 0, cap.size())), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick(2);

        cap.delete();
        offer(8'hC3, 1'b1);
        tick(L + 3);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        stream("single_c3", {4'b1011, 8'hC3, 1'b0, 1'b0}, L + 1, at);
`else
        stream("single_c3", {4'b1011, 8'hC3, 1'b0}, L + 1, at);
`endif
        chk("single_busy_cycles", 32'(count_bit(2, 0, cap.size())), 32'(L));
        chk("single_start_pulses", 32'(count_bit(1, 0, cap.size())), 32'd1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
        cap.delete();
        offer(8'h01, 1'b1);
        tick(L + 3);
        stream("parity_01", {4'b1011, 8'h01, 1'b1}, L, at);
`endif

        cap.delete();
        offer(8'hFF, 1'b0);
        offer(8'h00, 1'b1);
        tick(L + 3);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        stream("b2b_ff_00", {4'b1011, 8'hFF, 1'b0, 4'b1011, 8'h00, 1'b0}, 2 * L, at);
`else
        stream("b2b_ff_00", {4'b1011, 8'hFF, 4'b1011, 8'h00}, 2 * L, at);
`endif
        at2 = find_start(at + 1);
        chk("b2b_start_spacing", 32'(at2 - at), 32'(L));
        chk("b2b_busy_cycles", 32'(count_bit(2, 0, cap.size())), 32'(2 * L));

        cap.delete();
        offer(8'h5A, 1'b0);
        for (int i = 0; i < L - 1; i++) begin
            bus.in_data = 8'(i * 37 + 1);
            tick(1);
        end
        offer(8'h96, 1'b1);
        tick(L + 3);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        stream("stall_hold", {4'b1011, 8'h5A, 1'b0, 4'b1011, 8'h96, 1'b0}, 2 * L, at);
`else
        stream("stall_hold", {4'b1011, 8'h5A, 4'b1011, 8'h96}, 2 * L, at);
`endif
        chk("stall_start_pulses", 32'(count_bit(1, 0, cap.size())), 32'd2);

        cap.delete();
        offer(8'hA5, 1'b1);
        repeat (PW + 3) @(posedge clk);
        #1;
        chk("pre_abort_busy", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_ser", 32'(bus.ser_out), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_start", 32'(bus.frame_start), 32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd1);
        tick(2);
        rst = 1'b0;
        cap.delete();
        tick(3);
        offer(8'h3C, 1'b1);
        tick(L + 3);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        stream("after_reset_3c", {4'b1011, 8'h3C, 1'b0, 1'b0}, L + 1, at);
`else
        stream("after_reset_3c", {4'b1011, 8'h3C, 1'b0}, L + 1, at);
`endif
        chk("no_partial_frame", 32'(count_bit(2, 0, at)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
